icache_tag_valid_ram: RTL and testbench

- Tag and valid storage for the direct-mapped instruction cache: 32 sets, one 23-bit tag and one valid bit per set.
- The I-cache controller addresses the array by set index, reads tag and valid combinationally, and writes either field independently on the clock edge.
- A built-in tag comparator produces the hit signal consumed by the fetch path.

---
 rtl/icache_tag_valid_ram.sv | 53 +++++
 tb/tb_icache_tag_valid_ram.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/icache_tag_valid_ram.sv
// Tag + valid storage for a 32-set direct-mapped I-cache, with built-in tag compare.
// Latency: reads and hit are combinational; writes take effect on the rising clk edge.
// Backpressure: none; the array accepts a write on every edge and never stalls the controller.
module icache_tag_valid_ram #(
   parameter int INDEX_W = 5,
   parameter int TAG_W   = 23
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [INDEX_W-1:0] index,
   input  logic               tag_wr,
   input  logic [TAG_W-1:0]   tag_wr_data,
   input  logic               val_wr,
   input  logic               val_wr_data,
   input  logic [TAG_W-1:0]   cmp_tag,
   output logic [TAG_W-1:0]   tag_out,
   output logic               val_out,
   output logic               hit
);

   localparam int DEPTH = 1 << INDEX_W;

   logic [TAG_W-1:0] tag_mem [DEPTH];
   logic [DEPTH-1:0] val_mem;

   // Tag array: cleared asynchronously so no entry is ever undefined; written only when tag_wr.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            tag_mem[i] <= '0;
         end
      end else if (tag_wr) begin
         tag_mem[index] <= tag_wr_data;
      end
   end

   // Valid array: independent enable so an entry can be invalidated while keeping its tag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         val_mem <= '0;
      end else if (val_wr) begin
         val_mem[index] <= val_wr_data;
      end
   end

   // Combinational read port; no bypass, so a write shows up only after its edge.
   always_comb begin
      tag_out = tag_mem[index];
      val_out = val_mem[index];
      hit     = val_out & (tag_out == cmp_tag);
   end

endmodule

// File: tb/tb_icache_tag_valid_ram.sv
// Bench for icache_tag_valid_ram: directed scenarios followed by randomized traffic.
// Outputs are compared against a simple array model of the cache tag/valid store.
// Inputs change on the falling edge; outputs are sampled 1 ns after either edge.
module tb_icache_tag_valid_ram;

   localparam int INDEX_W = 5;
   localparam int TAG_W   = 23;
   localparam int DEPTH   = 32;

   logic               clk = 1'b0;
   logic               reset;
   logic [INDEX_W-1:0] index;
   logic               tag_wr;
   logic [TAG_W-1:0]   tag_wr_data;
   logic               val_wr;
   logic               val_wr_data;
   logic [TAG_W-1:0]   cmp_tag;
   logic [TAG_W-1:0]   tag_out;
   logic               val_out;
   logic               hit;

   icache_tag_valid_ram #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .index       (index),
      .tag_wr      (tag_wr),
      .tag_wr_data (tag_wr_data),
      .val_wr      (val_wr),
      .val_wr_data (val_wr_data),
      .cmp_tag     (cmp_tag),
      .tag_out     (tag_out),
      .val_out     (val_out),
      .hit         (hit)
   );

   always #5 clk = ~clk;

   // Reference model: the cache state as plain arrays.
   int unsigned ref_tag [DEPTH];
   bit          ref_val [DEPTH];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h (t=%0t idx=%0d)", name, got, exp, $time, index);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) begin
         ref_tag[i] = 0;
         ref_val[i] = 1'b0;
      end
   endtask

   task automatic check_read(input string name);
      int unsigned et;
      bit          ev;
      bit          eh;
      et = ref_tag[index];
      ev = ref_val[index];
      eh = ev && (et == 32'(cmp_tag));
      chk({name, ".tag"}, 32'(tag_out), et);
      chk({name, ".val"}, 32'(val_out), 32'(ev));
      chk({name, ".hit"}, 32'(hit), 32'(eh));
   endtask

   // One write cycle: drive on the falling edge, apply at the rising edge, check after it.
   task automatic wr(input int idx, input bit tw, input int unsigned td,
                     input bit vw, input bit vd, input string name);
      @(negedge clk);
      index       = INDEX_W'(idx);
      tag_wr      = tw;
      tag_wr_data = TAG_W'(td);
      val_wr      = vw;
      val_wr_data = vd;
      @(posedge clk);
      if (reset) begin
         if (tw) ref_tag[idx] = td & 32'h7fffff;
         if (vw) ref_val[idx] = vd;
      end
      #1;
      tag_wr = 1'b0;
      val_wr = 1'b0;
      check_read(name);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; index = '0; tag_wr = 1'b0; tag_wr_data = '0;
      val_wr = 1'b0; val_wr_data = 1'b0; cmp_tag = '0;
      model_clear();
      #50;

      // Reset state over every entry, including cmp_tag = 0 (must not hit).
      for (int i = 0; i < DEPTH; i++) begin
         index = INDEX_W'(i);
         #1;
         chk("rst.tag", 32'(tag_out), 0);
         chk("rst.val", 32'(val_out), 0);
         chk("rst.hit", 32'(hit), 0);
      end

      @(negedge clk);
      reset = 1'b1;

      // Write both fields at set 12, then compare against matching and neighbouring tags.
      cmp_tag = 23'h000abc;
      wr(12, 1, 32'h000abc, 1, 1, "wr_both");
      chk("wr_both.hit_exp1", 32'(hit), 1);
      cmp_tag = 23'h000abd;
      #1;
      chk("wr_both.miss", 32'(hit), 0);

      // Isolation: another set is untouched; returning is combinational.
      index = 5'b10100;
      cmp_tag = '0;
      #1;
      check_read("iso_other");
      index = 5'b01100;
      cmp_tag = 23'h000abc;
      #1;
      check_read("iso_back");

      // Invalidate only: tag retained, no hit.
      wr(12, 0, 0, 1, 0, "inval");
      chk("inval.tag_kept", 32'(tag_out), 32'h000abc);
      // Tag only: valid stays 0.
      cmp_tag = 23'h7fffff;
      wr(12, 1, 32'h7fffff, 0, 1, "tag_only");

      // Async reset between edges; writes during reset are dropped.
      cmp_tag = 23'h123456;
      wr(31, 1, 32'h123456, 1, 1, "pre_rst");
      #2;
      reset = 1'b0;
      model_clear();
      #1;
      check_read("async_rst");
      tag_wr = 1'b1; tag_wr_data = 23'h0f0f0f; val_wr = 1'b1; val_wr_data = 1'b1;
      @(posedge clk);
      #1;
      check_read("rst_wr_ignored");
      @(negedge clk);
      tag_wr = 1'b0; val_wr = 1'b0;
      #1;
      reset = 1'b1;
      #1;
      check_read("after_release");
      index = 5'd12;
      cmp_tag = '0;
      #1;
      check_read("after_release12");

      // Back-to-back writes on consecutive edges.
      wr(0, 1, 32'h1, 1, 1, "b2b0");
      wr(1, 1, 32'h2, 1, 1, "b2b1");
      index = 5'd0; cmp_tag = 23'h1;
      #1;
      check_read("b2b_read0");
      index = 5'd1; cmp_tag = 23'h2;
      #1;
      check_read("b2b_read1");

      // Randomized traffic; small tag space so hits and aliasing actually occur.
      for (int n = 0; n < 400; n++) begin
         int          ri;
         bit          rtw, rvw, rvd;
         int unsigned rtd;
         @(negedge clk);
         ri  = $urandom_range(DEPTH - 1);
         rtw = ($urandom_range(2) == 0);
         rvw = ($urandom_range(2) == 0);
         rvd = ($urandom_range(3) != 0);
         rtd = ($urandom_range(3) == 0) ? $urandom() : $urandom_range(7);
         index       = INDEX_W'(ri);
         tag_wr      = rtw;
         tag_wr_data = TAG_W'(rtd);
         val_wr      = rvw;
         val_wr_data = rvd;
         cmp_tag     = ($urandom_range(1) == 0) ? TAG_W'(ref_tag[ri]) : TAG_W'($urandom_range(7));
         #1;
         check_read("rnd_pre");
         if ($urandom_range(60) == 0) begin
            reset = 1'b0;
            model_clear();
            #1;
            check_read("rnd_rst");
            @(posedge clk);
            #1;
            reset = 1'b1;
         end else begin
            @(posedge clk);
            if (rtw) ref_tag[ri] = rtd & 32'h7fffff;
            if (rvw) ref_val[ri] = rvd;
            #1;
            check_read("rnd_post");
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
